// File: rtl/bounded_updown_counter_pkg.sv
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared types for the bounded up/down counter: end-of-range
//                mode encoding and the run/halt state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    // End-of-range behaviour selected by the MODE input
    typedef enum logic [1:0] {
        MODE_SAT     = 2'd0,
        MODE_WRAP    = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_ONESHOT = 2'd3
    } cnt_mode_e;

    // Counting state; HALT is only entered from ONESHOT
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fsm_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/bounded_updown_counter_if.sv
// ============================================================================
//  Module      : bounded_updown_counter_if
//  Description : Control/status bundle of the bounded up/down counter.
//                Signal suffixes are from the counter's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bounded_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             load_i;
    logic [WIDTH-1:0] in_i;
    logic             up_i;
    logic             down_i;
    logic [1:0]       mode_i;
    logic [WIDTH-1:0] limit_lo_i;
    logic [WIDTH-1:0] limit_hi_i;
    logic [WIDTH-1:0] step_i;
    logic [WIDTH-1:0] counter_o;
    logic             high_o;
    logic             low_o;
    logic             dir_o;
    logic             tc_o;
    logic             done_o;
    logic             cfg_err_o;

    // Controller side: drives requests and configuration
    modport master (
        output load_i, in_i, up_i, down_i, mode_i, limit_lo_i, limit_hi_i, step_i,
        input  counter_o, high_o, low_o, dir_o, tc_o, done_o, cfg_err_o
    );

    // Counter side
    modport slave (
        input  load_i, in_i, up_i, down_i, mode_i, limit_lo_i, limit_hi_i, step_i,
        output counter_o, high_o, low_o, dir_o, tc_o, done_o, cfg_err_o
    );

endinterface : bounded_updown_counter_if

`default_nettype wire

// File: rtl/bounded_updown_counter_bound_step_unit.sv
// ============================================================================
//  Module      : bound_step_unit
//  Description : Combinational step datapath. Computes Counter +/- STEP in
//                WIDTH+1 bits, detects overshoot/landing on the bound in the
//                travel direction and applies the end-of-range mode rule.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bound_step_unit
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] cnt_i,
    input  wire logic [WIDTH-1:0] step_i,
    input  wire logic [WIDTH-1:0] lo_i,
    input  wire logic [WIDTH-1:0] hi_i,
    input  wire logic             dir_up_i,
    input  wire cnt_mode_e        mode_i,
    output logic      [WIDTH-1:0] next_o,
    output logic                  reached_o,
    output logic                  hit_bound_o,
    output logic                  flip_dir_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_bound;
    logic [WIDTH-1:0] w_opp;
    logic             w_over;
    logic             w_land;
    logic             w_at_bound;

    // Raw arithmetic and bound detection in the travel direction
    always_comb begin
        w_sum   = {1'b0, cnt_i} + {1'b0, step_i};
        w_diff  = {1'b0, cnt_i} - {1'b0, step_i};
        w_bound = dir_up_i ? hi_i : lo_i;
        w_opp   = dir_up_i ? lo_i : hi_i;
        if (dir_up_i) begin
            w_raw  = w_sum[WIDTH-1:0];
            w_over = (w_sum > {1'b0, hi_i});
            w_land = (w_sum == {1'b0, hi_i});
        end else begin
            // The extra MSB is the borrow: going below zero is an overshoot
            w_raw  = w_diff[WIDTH-1:0];
            w_over = w_diff[WIDTH] || (w_diff < {1'b0, lo_i});
            w_land = (w_diff == {1'b0, lo_i});
        end
        w_at_bound = (cnt_i == w_bound);
    end

    // Mode-specific resolution of the reached-bound case
    always_comb begin
        next_o      = w_raw;
        reached_o   = w_over || w_land;
        hit_bound_o = 1'b0;
        flip_dir_o  = 1'b0;
        if (w_over || w_land) begin
            case (mode_i)
                MODE_WRAP: begin
                    next_o      = w_opp;
                    hit_bound_o = 1'b1;
                end
                MODE_BOUNCE: begin
                    next_o      = w_bound;
                    hit_bound_o = 1'b1;
                    flip_dir_o  = 1'b1;
                end
                default: begin
                    // Saturating behaviour: a step that starts on the bound is not a new arrival
                    next_o      = w_bound;
                    hit_bound_o = !w_at_bound;
                end
            endcase
        end
    end

endmodule : bound_step_unit

`default_nettype wire

// File: rtl/bounded_updown_counter.sv
// ============================================================================
//  Module      : bounded_updown_counter
//  Description : Bounded up/down counter with run-time limits, programmable
//                step, saturate/wrap/bounce/one-shot end-of-range modes,
//                terminal-count pulse and sticky one-shot completion.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bounded_updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    bounded_updown_counter_if.slave bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    fsm_e             state_q, state_d;

    cnt_mode_e        w_mode;
    logic             w_cfg_err;
    logic             w_step_en;
    logic             w_dir_up;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next;
    logic             w_reached;
    logic             w_hit;
    logic             w_flip;

    // Request decode, direction selection and load clamping
    always_comb begin
        w_mode    = cnt_mode_e'(bus.mode_i);
        w_cfg_err = (bus.limit_lo_i > bus.limit_hi_i);
        w_step_en = (bus.up_i || bus.down_i) && (bus.step_i != '0)
                    && !w_cfg_err && (state_q == ST_RUN);
        // BOUNCE uses its own direction register; otherwise Down wins over Up
        w_dir_up  = (w_mode == MODE_BOUNCE) ? dir_q : !bus.down_i;
        if (w_cfg_err) begin
            w_load_val = bus.in_i;
        end else if (bus.in_i < bus.limit_lo_i) begin
            w_load_val = bus.limit_lo_i;
        end else if (bus.in_i > bus.limit_hi_i) begin
            w_load_val = bus.limit_hi_i;
        end else begin
            w_load_val = bus.in_i;
        end
    end

    bound_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .cnt_i       (cnt_q),
        .step_i      (bus.step_i),
        .lo_i        (bus.limit_lo_i),
        .hi_i        (bus.limit_hi_i),
        .dir_up_i    (w_dir_up),
        .mode_i      (w_mode),
        .next_o      (w_next),
        .reached_o   (w_reached),
        .hit_bound_o (w_hit),
        .flip_dir_o  (w_flip)
    );

    // Next-state logic: Load beats any step; TC defaults to a single-cycle pulse
    always_comb begin
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        state_d = state_q;
        if (bus.load_i) begin
            cnt_d   = w_load_val;
            dir_d   = 1'b1;
            done_d  = 1'b0;
            state_d = ST_RUN;
        end else if (w_step_en) begin
            cnt_d = w_next;
            tc_d  = w_hit;
            if (w_flip) begin
                dir_d = !dir_q;
            end
            if ((w_mode == MODE_ONESHOT) && w_reached) begin
                done_d  = 1'b1;
                state_d = ST_HALT;
            end
        end
    end

    // Run/halt state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, direction, terminal-count and completion registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= RST_VAL;
            dir_q  <= 1'b1;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    // Status outputs; the limit flags and config error follow the limits combinationally
    always_comb begin
        bus.counter_o = cnt_q;
        bus.high_o    = (cnt_q >= bus.limit_hi_i);
        bus.low_o     = (cnt_q <= bus.limit_lo_i);
        bus.dir_o     = dir_q;
        bus.tc_o      = tc_q;
        bus.done_o    = done_q;
        bus.cfg_err_o = w_cfg_err;
    end

endmodule : bounded_updown_counter

`default_nettype wire
